// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: prefetches words from a 1-cycle-latency program memory
// into a 2-entry FIFO, handles redirects with epoch tagging, and halts on illegal PCs.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0400_0000,
  parameter int          MEM_WORDS = 18,
  parameter int          AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_bits,
  output logic [31:0]   inst_pc,
  output logic          fetch_fault,
  output logic [31:0]   fault_pc
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  function automatic logic pc_legal(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - RESET_PC;
    return (pc[1:0] == 2'b00) && (pc >= RESET_PC) && ((off >> 2) < MEM_WORDS_U);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_bits_q [2];
  logic [31:0] fifo_bits_d [2];
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_epoch_q, out_epoch_d;
  logic        epoch_q, epoch_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic       head_vld;
  logic       pop;
  logic       push;
  logic [1:0] cnt_pop;
  logic       issue;

  assign head_vld = !rst && (cnt_q != 2'd0);
  assign pop      = head_vld && inst_ready;
  // A response is kept only if it belongs to the current epoch and no flush is underway.
  assign push     = out_vld_q && (out_epoch_q == epoch_q) && !redirect_valid;
  assign cnt_pop  = cnt_q - 2'(pop);
  // Occupancy after this cycle's pop plus the response landing now must leave room.
  assign issue    = !rst && (state_q == RUN) && !redirect_valid && pc_legal(fetch_pc_q)
                    && ((cnt_pop + 2'(out_vld_q)) < 2'd2);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_bits_d = fifo_bits_q;
    out_vld_d   = 1'b0;
    out_pc_d    = out_pc_q;
    out_epoch_d = out_epoch_q;
    epoch_d     = epoch_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;

    if (pop) begin
      fifo_pc_d[0]   = fifo_pc_q[1];
      fifo_bits_d[0] = fifo_bits_q[1];
    end
    if (push) begin
      fifo_pc_d[cnt_pop[0]]   = out_pc_q;
      fifo_bits_d[cnt_pop[0]] = imem_rdata;
    end
    cnt_d = redirect_valid ? 2'd0 : (cnt_pop + 2'(push));

    if (issue) begin
      out_vld_d   = 1'b1;
      out_pc_d    = fetch_pc_q;
      out_epoch_d = epoch_q;
      fetch_pc_d  = fetch_pc_q + 32'd4;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = ~epoch_q;
    end

    unique case (state_q)
      RUN: begin
        if (!redirect_valid && !pc_legal(fetch_pc_q)) begin
          state_d    = HALT;
          fault_d    = 1'b1;
          fault_pc_d = fetch_pc_q;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          if (pc_legal(redirect_pc)) begin
            state_d = RUN;
            fault_d = 1'b0;
          end else begin
            fault_pc_d = redirect_pc;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      cnt_q      <= 2'd0;
      out_vld_q  <= 1'b0;
      epoch_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      epoch_q    <= epoch_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_bits_q <= fifo_bits_d;
    out_pc_q    <= out_pc_d;
    out_epoch_q <= out_epoch_d;
  end

  assign imem_rd_en  = issue;
  assign imem_addr   = AW'((fetch_pc_q - RESET_PC) >> 2);
  assign inst_valid  = head_vld;
  assign inst_bits   = head_vld ? fifo_bits_q[0] : 32'd0;
  assign inst_pc     = head_vld ? fifo_pc_q[0] : 32'd0;
  assign fetch_fault = !rst && fault_q;
  assign fault_pc    = rst ? 32'd0 : fault_pc_q;

endmodule

// File: doc/rv32i_fetch_unit.md
RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0400_0000: fetch address after reset and base byte address of program memory.
REQ-002 Parameter MEM_WORDS, default 18: number of 32-bit program-memory words.
REQ-003 Parameter AW, default $clog2(MEM_WORDS): word-index width.
REQ-004 clk  in  1: the block's single clock; all state updates on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 imem_rd_en  out  1: read strobe to program memory.
REQ-007 imem_addr  out  AW: word index, equal to (fetch_pc - RESET_PC) >> 2.
REQ-008 imem_rdata  in  32: memory data, valid exactly one cycle after imem_rd_en.
REQ-009 redirect_valid  in  1: core requests a fetch from redirect_pc (branch/jump).
REQ-010 redirect_pc  in  32: target byte address.
REQ-011 inst_valid  out  1: inst_bits/inst_pc hold a fetched instruction.
REQ-012 inst_ready  in  1: core accepts the instruction; transfer occurs when inst_valid & inst_ready.
REQ-013 inst_bits  out  32: raw instruction word for the core.
REQ-014 inst_pc  out  32: byte address of inst_bits.
REQ-015 fetch_fault  out  1: sticky; an illegal fetch address was reached.
REQ-016 fault_pc  out  32: offending byte address, valid while fetch_fault = 1.

Function
REQ-017 Internal state: fetch_pc (32 b), 2-entry instruction FIFO of {pc, bits}, one outstanding-read flag with its pc, and an epoch bit.
REQ-018 FSM states: RUN and HALT; reset enters RUN.
REQ-019 In RUN, imem_rd_en = 1 when FIFO occupancy + outstanding < 2, fetch_pc is legal, and no redirect is present this cycle; fetch_pc then increments by 4.
REQ-020 A fetch_pc is legal when fetch_pc[1:0] = 0, fetch_pc >= RESET_PC, and (fetch_pc - RESET_PC) >> 2 < MEM_WORDS, using 32-bit unsigned compares with no wrap.
REQ-021 Read latency: the response is written to the FIFO at the end of the cycle after imem_rd_en, so inst_valid rises two cycles after the request.
REQ-022 Steady-state throughput is one instruction per cycle while inst_ready = 1.
REQ-023 FIFO output is registered and in order; inst_bits/inst_pc stay stable while inst_valid = 1 and inst_ready = 0.
REQ-024 Full FIFO with inst_ready = 0: no new requests are issued and no data is lost.
REQ-025 Redirect, next cycle: fetch_pc = redirect_pc, FIFO flushed, epoch toggled, and any in-flight response tagged with the old epoch is discarded.
REQ-026 Redirect coinciding with an output transfer: the transfer completes, and all remaining entries are flushed.
REQ-027 Redirect in HALT with a legal target: clears fetch_fault, returns to RUN, and fetches from the target.
REQ-028 Redirect in HALT with an illegal target: stays in HALT and updates fault_pc to the new target.
REQ-029 Illegal fetch_pc in RUN: no request; go to HALT; fetch_fault = 1; fault_pc = fetch_pc.
REQ-030 In HALT: entries already buffered still drain normally; no new reads are issued.
REQ-031 Increment past the last word causes a HALT fault at RESET_PC + 4*MEM_WORDS, never an address wrap.

Reset
REQ-032 While rst = 1: fetch_pc = RESET_PC; FIFO empty; outstanding and epoch cleared; state RUN.
REQ-033 While rst = 1: imem_rd_en = 0, inst_valid = 0, inst_bits = 0, inst_pc = 0, fetch_fault = 0, fault_pc = 0.
REQ-034 Reset asserted mid-operation takes effect on the next edge: buffered and in-flight data are dropped, and any response arriving after reset is ignored.
REQ-035 First cycle after rst falls: imem_rd_en = 1, imem_addr = 0.

Verification
REQ-036 Release reset, hold inst_ready = 1 -> inst_valid rises on cycle 2 with inst_pc 0x0400_0000, then one instruction per cycle at pc +4, in order.
REQ-037 Hold inst_ready = 0 for 5 cycles, then set it to 1 -> at most 2 requests issue during the stall, and output resumes with no gap, loss or duplicate.
REQ-038 Redirect to 0x0400_0020 while a read is in flight -> the stale response is dropped, and the next delivered inst_pc is 0x0400_0020 (imem_addr 8).
REQ-039 Run sequentially with MEM_WORDS = 18 -> last delivered inst_pc is 0x0400_0044, then fetch_fault = 1 with fault_pc = 0x0400_0048.
REQ-040 Redirect to 0x0400_0006 -> HALT with fault_pc 0x0400_0006; a following redirect to 0x0400_0000 clears the fault and fetching resumes.
REQ-041 Assert rst for 1 cycle with the FIFO full -> inst_valid = 0 next cycle, and fetching restarts at 0x0400_0000.
